tt_um_seven_segment_multidigit: RTL and testbench

TT_UM_SEVEN_SEGMENT_MULTIDIGIT -- requirements
Module: tt_um_seven_segment_multidigit

---
 rtl/tt_um_seven_segment_multidigit_pkg.sv | 27 ++
 rtl/tt_um_seven_segment_multidigit_seg7.sv | 25 ++
 rtl/tt_um_seven_segment_multidigit.sv | 123 ++++++++++++
 tb/tb_tt_um_seven_segment_multidigit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_seven_segment_multidigit_pkg.sv
// Shared types and constants for the multi-digit BCD counter with a scanned
// seven-segment display.
package tt_um_seven_segment_multidigit_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MIN = 4'd0;
  localparam bcd_t BCD_MAX = 4'd9;

  // Segment patterns, bit 0 = segment a ... bit 6 = segment g, active high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int          MIN_DIGITS   = 1;
  localparam int          MAX_DIGITS   = 8;
  localparam logic [15:0] MIN_SCAN_DIV = 16'd1;

endpackage

// File: rtl/tt_um_seven_segment_multidigit_seg7.sv
// BCD to seven-segment decoder; codes above 9 blank the digit.
module tt_um_seven_segment_multidigit_seg7
  import tt_um_seven_segment_multidigit_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] segments
);

  always_comb begin
    unique case (digit)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tt_um_seven_segment_multidigit.sv
// Prescaled up/down BCD counter of NUM_DIGITS digits, shown one digit at a time
// on a multiplexed seven-segment display with a heartbeat on uo_out[7].
module tt_um_seven_segment_multidigit
  import tt_um_seven_segment_multidigit_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT     = 24'd10_000_000,
  parameter int          NUM_DIGITS    = 4,
  parameter logic [15:0] SCAN_DIV      = 16'd10_000,
  parameter int          COMPARE_SHIFT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS || SCAN_DIV < MIN_SCAN_DIV) begin : g_bad_params
    $error("tt_um_seven_segment_multidigit: illegal NUM_DIGITS or SCAN_DIV");
  end

  logic        pause;
  logic        dir_down;
  logic [23:0] sel_ext;
  logic [23:0] compare;
  logic [23:0] prescaler;
  logic        tick;
  logic        heartbeat;

  assign pause    = ui_in[6];
  assign dir_down = ui_in[7];
  assign sel_ext  = {18'd0, ui_in[5:0]};
  assign compare  = (ui_in[5:0] == 6'd0) ? MAX_COUNT : (sel_ext << COMPARE_SHIFT);

  // ">=" rather than "==" so a compare lowered below the running count
  // reloads on the next cycle instead of wrapping through 2^24.
  assign tick = !pause && (prescaler >= compare);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      heartbeat <= 1'b0;
    end else if (!pause) begin
      prescaler <= tick ? 24'd0 : prescaler + 24'd1;
      if (tick) heartbeat <= ~heartbeat;
    end
  end

  bcd_t [NUM_DIGITS-1:0] digits;
  bcd_t [NUM_DIGITS-1:0] digits_next;
  logic [NUM_DIGITS-1:0] at_limit;
  logic [NUM_DIGITS-1:0] step;

  // A digit steps when the tick reaches it: every lower digit is at its
  // rollover value (9 counting up, 0 counting down).
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign at_limit[i] = dir_down ? (digits[i] == BCD_MIN) : (digits[i] == BCD_MAX);

    if (i == 0) begin : g_first
      assign step[i] = tick;
    end else begin : g_chain
      assign step[i] = tick && (&at_limit[i-1:0]);
    end

    assign digits_next[i] = !step[i]    ? digits[i] :
                            at_limit[i] ? (dir_down ? BCD_MAX : BCD_MIN) :
                            dir_down    ? digits[i] - 4'd1 : digits[i] + 4'd1;
  end

  // NOTE: the digit bank is a handful of flops, not a RAM, so it is cleared by
  // the asynchronous reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digits <= '0;
    else        digits <= digits_next;
  end

  logic [15:0]      scan_div;
  logic [IDX_W-1:0] scan_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_div <= '0;
      scan_idx <= '0;
    end else if (scan_div == SCAN_DIV - 16'd1) begin
      scan_div <= '0;
      scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_div <= scan_div + 16'd1;
    end
  end

  bcd_t       shown_digit;
  logic [6:0] segments;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no path leaves a value held (no latch).
  always_comb begin
    shown_digit = BCD_MIN;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) shown_digit = digits[i];
    end
  end

  tt_um_seven_segment_multidigit_seg7 u_seg7 (
    .digit    (shown_digit),
    .segments (segments)
  );

  assign uo_out  = {heartbeat, segments};
  assign uio_out = 8'd1 << scan_idx;
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_tt_um_seven_segment_multidigit.sv
// Bench for the scanned BCD counter: a 4-digit instance for counting and a
// 3-digit instance (SCAN_DIV=3) for scan sequencing, driven from shared inputs.
module tb_tt_um_seven_segment_multidigit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out_a, uio_out_a, uio_oe_a;
  logic [7:0] uo_out_b, uio_out_b, uio_oe_b;

  always #5 clk = ~clk;

  tt_um_seven_segment_multidigit #(
    .MAX_COUNT(24'd0), .NUM_DIGITS(4), .SCAN_DIV(16'd2), .COMPARE_SHIFT(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out_a), .uio_out(uio_out_a), .uio_oe(uio_oe_a)
  );

  tt_um_seven_segment_multidigit #(
    .MAX_COUNT(24'd0), .NUM_DIGITS(3), .SCAN_DIV(16'd3), .COMPARE_SHIFT(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out_b), .uio_out(uio_out_b), .uio_oe(uio_oe_b)
  );

  typedef struct {
    logic [7:0] ui;
    int         ticks;
    int         count;
    int         cycles;
  } vec_t;

  typedef struct {
    string name;
    int    count;
    int    cycles;
    logic  hb;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  logic hb_model = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  function automatic int seg_to_digit(input logic [6:0] s);
    case (s)
      7'h3F: return 0;
      7'h06: return 1;
      7'h5B: return 2;
      7'h4F: return 3;
      7'h66: return 4;
      7'h6D: return 5;
      7'h7D: return 6;
      7'h07: return 7;
      7'h7F: return 8;
      7'h6F: return 9;
      default: return 15;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [7:0] v, input int n);
    int idx = -1;
    bit bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        if (idx != -1 || i >= n) bad = 1'b1;
        idx = i;
      end
    end
    return bad ? -1 : idx;
  endfunction

  // Runs unpaused until n heartbeat toggles are seen, then re-pauses before
  // the next edge. Called at a falling edge.
  task automatic run_ticks(input string name, input logic [7:0] ui, input int n, output int cycles);
    int   seen = 0;
    int   budget = n * 70 + 100;
    logic hb_prev = uo_out_a[7];
    cycles = 0;
    ui_in = ui;
    while (seen < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (uo_out_a[7] != hb_prev) begin
        seen++;
        hb_prev = uo_out_a[7];
      end
    end
    ui_in = ui | 8'h40;
    if (seen < n) check({name, "_timeout"}, seen, n);
  endtask

  // Watches both scan sequences long enough to see every digit of each.
  task automatic read_display(output int main_val, output int scan_val, output int bad);
    int dm[4];
    int ds[3];
    int ia, ib;
    foreach (dm[i]) dm[i] = 15;
    foreach (ds[i]) ds[i] = 15;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ia = onehot_idx(uio_out_a, 4);
      ib = onehot_idx(uio_out_b, 3);
      if (ia < 0) bad++; else dm[ia] = seg_to_digit(uo_out_a[6:0]);
      if (ib < 0) bad++; else ds[ib] = seg_to_digit(uo_out_b[6:0]);
    end
    main_val = dm[0] + 10 * dm[1] + 100 * dm[2] + 1000 * dm[3];
    scan_val = ds[0] + 10 * ds[1] + 100 * ds[2];
  endtask

  task automatic do_run(input string name, input logic [7:0] ui, input int n,
                        input int exp_count, input int exp_cycles);
    exp_t e;
    int   cycles, main_val, scan_val, bad;
    hb_model = hb_model ^ n[0];
    e = '{name: name, count: exp_count, cycles: exp_cycles, hb: hb_model};
    sb.push_back(e);
    run_ticks(name, ui, n, cycles);
    read_display(main_val, scan_val, bad);
    e = sb.pop_front();
    check({e.name, "_cycles"}, cycles, e.cycles);
    check({e.name, "_count"}, main_val, e.count);
    check({e.name, "_count3"}, scan_val, e.count % 1000);
    check({e.name, "_heartbeat"}, int'(uo_out_a[7]), int'(e.hb));
    check({e.name, "_onehot"}, bad, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_uo_a"}, uo_out_a, 8'h3F);
    check({name, "_uio_a"}, uio_out_a, 8'h01);
    check({name, "_oe_a"}, uio_oe_a, 8'hFF);
    check({name, "_uo_b"}, uo_out_b, 8'h3F);
    check({name, "_uio_b"}, uio_out_b, 8'h01);
    check({name, "_oe_b"}, uio_oe_b, 8'hFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes, hb_changes;
    logic [7:0] prev_uio;
    logic       hb_before;

    // {ui_in, ticks, count after, cycles taken}; prescaler is 0 at each start.
    vecs[0] = '{8'h01,   20,   20,   40};
    vecs[1] = '{8'h81,    5,   15,   10};
    vecs[2] = '{8'h81,   16, 9999,   32};
    vecs[3] = '{8'h00,    1,    0,    1};
    vecs[4] = '{8'h00, 9999, 9999, 9999};
    vecs[5] = '{8'h00,    1,    0,    1};
    vecs[6] = '{8'h80,    1, 9999,    1};
    vecs[7] = '{8'h02,    3,    2,    9};
    vecs[8] = '{8'h83,    4, 9998,   16};

    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h40;
    rst_n  = 1'b0;
    #2;
    check_reset_outputs("reset");

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("scan_seq_0", uio_out_b, 8'h01);
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("scan_seq_%0d", k), uio_out_b, 1 << ((k / 3) % 3));
    end

    for (int i = 0; i < 9; i++)
      do_run($sformatf("row%0d", i), vecs[i].ui, vecs[i].ticks, vecs[i].count, vecs[i].cycles);

    // Pause mid-period with the prescaler at 2 of compare 3.
    ui_in = 8'h03;
    repeat (2) @(negedge clk);
    ui_in = 8'h43;
    hb_before = uo_out_a[7];
    prev_uio = uio_out_a;
    changes = 0;
    hb_changes = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uio_out_a != prev_uio) changes++;
      if (uo_out_a[7] != hb_before) hb_changes++;
      prev_uio = uio_out_a;
    end
    check("pause_hb_frozen", hb_changes, 0);
    check("pause_scan_moves", changes, 25);
    do_run("pause_resume", 8'h03, 1, 9999, 2);

    // Prescaler runs to 40 under compare 63, then compare drops to 16.
    ui_in = 8'h3F;
    repeat (40) @(negedge clk);
    do_run("compare_lowered", 8'h10, 1, 0, 1);
    do_run("compare_reload", 8'h10, 1, 1, 17);

    // Direction flips after the period starts; the tick counts down.
    ui_in = 8'h03;
    repeat (2) @(negedge clk);
    do_run("dir_late", 8'h83, 1, 0, 2);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    hb_model = 1'b0;
    do_run("preload_473", 8'h00, 473, 473, 473);

    // Asynchronous reset between edges at count 0473.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk) rst_n = 1'b1;
    hb_model = 1'b0;
    do_run("restart", 8'h01, 20, 20, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
